// File: rtl/timer_led_periph.sv
// Bus-mapped LED register plus 64-bit prescaled mtime/mtimecmp timer raising a level irq.
// Latency: response (rvalid/rdata/err) 1 cycle after req; never backpressures (gnt = req).
module timer_led_periph #(
    parameter int unsigned LedWidth    = 4,
    parameter int unsigned PrescaleW   = 16,
    parameter logic [63:0] CmpResetVal = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    output logic [LedWidth-1:0] led_o,
    output logic                irq_timer_o
);

    localparam logic [4:0] OffLed      = 5'h00;
    localparam logic [4:0] OffMtimeLo  = 5'h04;
    localparam logic [4:0] OffMtimeHi  = 5'h08;
    localparam logic [4:0] OffCmpLo    = 5'h0C;
    localparam logic [4:0] OffCmpHi    = 5'h10;
    localparam logic [4:0] OffPrescale = 5'h14;

    logic [4:0]           off;
    logic                 addr_ok;
    logic                 wr;
    logic                 tick;
    logic                 unused_addr;

    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [LedWidth-1:0]  led_q, led_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          cmp_q, cmp_d;
    logic [PrescaleW-1:0] presc_q, presc_d;
    logic [PrescaleW-1:0] pcnt_q, pcnt_d;
    logic                 irq_q, irq_d;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign off         = addr_i[4:0];
    assign unused_addr = ^addr_i[31:5];
    assign gnt_o       = req_i;

    always_comb begin
        addr_ok = 1'b0;
        case (off)
            OffLed, OffMtimeLo, OffMtimeHi,
            OffCmpLo, OffCmpHi, OffPrescale: addr_ok = 1'b1;
            default:                         addr_ok = 1'b0;
        endcase
    end

    assign wr   = req_i & we_i & addr_ok;
    assign tick = (pcnt_q == presc_q);

    always_comb begin
        rvalid_d = req_i;
        err_d    = req_i & ~addr_ok;
        rdata_d  = '0;
        if (req_i && !we_i && addr_ok) begin
            case (off)
                OffLed:      rdata_d = 32'(led_q);
                OffMtimeLo:  rdata_d = mtime_q[31:0];
                OffMtimeHi:  rdata_d = mtime_q[63:32];
                OffCmpLo:    rdata_d = cmp_q[31:0];
                OffCmpHi:    rdata_d = cmp_q[63:32];
                OffPrescale: rdata_d = 32'(presc_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // LED and PRESCALE are narrower than the bus, so merge bit-by-bit against their byte lane.
    always_comb begin
        led_d   = led_q;
        presc_d = presc_q;
        if (wr && off == OffLed) begin
            for (int b = 0; b < LedWidth; b++) begin
                if (be_i[b/8]) led_d[b] = wdata_i[b];
            end
        end
        if (wr && off == OffPrescale) begin
            for (int b = 0; b < PrescaleW; b++) begin
                if (be_i[b/8]) presc_d[b] = wdata_i[b];
            end
        end
    end

    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + PrescaleW'(1);
        if (wr && off == OffPrescale) pcnt_d = '0;
    end

    // A software write to either mtime half suppresses the whole 64-bit increment.
    always_comb begin
        mtime_d = mtime_q;
        if (wr && (off == OffMtimeLo || off == OffMtimeHi)) begin
            if (off == OffMtimeLo) mtime_d[31:0]  = lane_merge(mtime_q[31:0], wdata_i, be_i);
            if (off == OffMtimeHi) mtime_d[63:32] = lane_merge(mtime_q[63:32], wdata_i, be_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        cmp_d = cmp_q;
        if (wr && off == OffCmpLo) cmp_d[31:0]  = lane_merge(cmp_q[31:0], wdata_i, be_i);
        if (wr && off == OffCmpHi) cmp_d[63:32] = lane_merge(cmp_q[63:32], wdata_i, be_i);
    end

    assign irq_d = (mtime_q >= cmp_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            led_q    <= '0;
            mtime_q  <= '0;
            cmp_q    <= CmpResetVal;
            presc_q  <= '0;
            pcnt_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            led_q    <= led_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            irq_q    <= irq_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign led_o       = led_q;
    assign irq_timer_o = irq_q;

endmodule

// File: tb/tb_timer_led_periph.sv
// Directed bench for timer_led_periph: back-to-back vector table plus timer/irq/reset sequences.
module tb_timer_led_periph;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, err, irq;
    logic [31:0] rdata;
    logic [3:0]  led;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timer_led_periph #(
        .LedWidth(4), .PrescaleW(16), .CmpResetVal(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .led_o(led), .irq_timer_o(irq)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        chk_led;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [3:0] b, input logic [4:0] o,
                       input logic [31:0] d, input logic [31:0] er_d, input logic ee,
                       input logic cl, input logic [3:0] el);
        vec_t v;
        v.we = w; v.be = b; v.off = o; v.wd = d; v.exp_rd = er_d; v.exp_err = ee;
        v.chk_led = cl; v.exp_led = el;
        tbl.push_back(v);
    endtask

    // One bus beat: drive at negedge, response sampled just after the following posedge.
    task automatic xfer(input logic w, input logic [3:0] b, input logic [4:0] o,
                        input logic [31:0] d, output logic gn, output logic rv,
                        output logic [31:0] rd, output logic er);
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = {27'h0, o}; wdata = d;
        #1 gn = gnt;
        @(posedge clk);
        #1;
        rv = rvalid; rd = rdata; er = err;
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_chk(input string name, input logic [4:0] o, input logic [31:0] d);
        logic gn, rv, er;
        logic [31:0] rd;
        xfer(1'b1, 4'hF, o, d, gn, rv, rd, er);
        check({name, "_rvalid"}, 64'(rv), 64'd1);
        check({name, "_err"}, 64'(er), 64'd0);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] o, input logic [31:0] exp);
        logic gn, rv, er;
        logic [31:0] rd;
        xfer(1'b0, 4'h0, o, 32'h0, gn, rv, rd, er);
        check({name, "_rvalid"}, 64'(rv), 64'd1);
        check({name, "_rdata"}, 64'(rd), 64'(exp));
    endtask

    initial begin
        logic gn, rv, er;
        logic [31:0] rd;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;

        // Reset values; PRESCALE=0 so mtime counts one per cycle from the first edge.
        add(0, 4'h0, 5'h04, 0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h08, 0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h00, 0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h0C, 0, 32'hFFFF_FFFF, 0, 0, 0);
        add(0, 4'h0, 5'h10, 0, 32'hFFFF_FFFF, 0, 0, 0);
        add(0, 4'h0, 5'h14, 0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h6, 0, 1, 4'h0);
        // LED writes, byte enables, no-op writes
        add(1, 4'h1, 5'h00, 32'h5, 32'h0, 0, 1, 4'h5);
        add(0, 4'h0, 5'h00, 0, 32'h5, 0, 0, 0);
        add(1, 4'h0, 5'h00, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h00, 0, 32'h5, 0, 0, 0);
        add(1, 4'hE, 5'h00, 32'hFFFF_FF0A, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h00, 0, 32'h5, 0, 0, 0);
        // Errors: unmapped and unaligned, reads and writes
        add(0, 4'h0, 5'h18, 0, 32'h0, 1, 0, 0);
        add(0, 4'h0, 5'h1C, 0, 32'h0, 1, 0, 0);
        add(0, 4'h0, 5'h02, 0, 32'h0, 1, 0, 0);
        add(1, 4'hF, 5'h18, 32'hF, 32'h0, 1, 0, 0);
        add(1, 4'hF, 5'h01, 32'hA, 32'h0, 1, 1, 4'h5);
        add(0, 4'h0, 5'h00, 0, 32'h5, 0, 0, 0);
        // Partial lane writes to MTIMECMP_LO and PRESCALE
        add(1, 4'h5, 5'h0C, 32'h1234_5678, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h0C, 0, 32'hFF34_FF78, 0, 0, 0);
        add(1, 4'hF, 5'h14, 32'hFFFF_1234, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h14, 0, 32'h0000_1234, 0, 0, 0);
        add(1, 4'h4, 5'h14, 32'h00AB_0000, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h14, 0, 32'h0000_1234, 0, 0, 0);
        // PRESCALE=3: tick every 4th cycle; rewrite of PRESCALE restarts the interval
        add(1, 4'hF, 5'h14, 32'h3, 32'h0, 0, 0, 0);
        add(1, 4'hF, 5'h08, 32'h0, 32'h0, 0, 0, 0);
        add(1, 4'hF, 5'h04, 32'h0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h1, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h1, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h1, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h1, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h2, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h2, 0, 0, 0);
        add(1, 4'hF, 5'h14, 32'h3, 32'h0, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h2, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h2, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h2, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h2, 0, 0, 0);
        add(0, 4'h0, 5'h04, 0, 32'h3, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 check("reset_rvalid", 64'(rvalid), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);
        check("reset_led", 64'(led), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            xfer(tbl[i].we, tbl[i].be, tbl[i].off, tbl[i].wd, gn, rv, rd, er);
            check($sformatf("v%0d_gnt", i), 64'(gn), 64'd1);
            check($sformatf("v%0d_rvalid", i), 64'(rv), 64'd1);
            check($sformatf("v%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
            check($sformatf("v%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
            if (tbl[i].chk_led) check($sformatf("v%0d_led", i), 64'(led), 64'(tbl[i].exp_led));
        end

        // irq rises one cycle after mtime reaches mtimecmp
        wr_chk("irq_psc0", 5'h14, 32'h0);
        wr_chk("irq_cmplo", 5'h0C, 32'h10);
        wr_chk("irq_mthi", 5'h08, 32'h0);
        wr_chk("irq_mtlo", 5'h04, 32'h0);
        wr_chk("irq_cmphi", 5'h10, 32'h0);
        for (int n = 2; n <= 20; n++) begin
            idle();
            check($sformatf("irq_n%0d", n), 64'(irq), (n >= 17) ? 64'd1 : 64'd0);
        end
        check("idle_rvalid", 64'(rvalid), 64'd0);
        check("idle_rdata", 64'(rdata), 64'd0);
        wr_chk("irq_cmphi1", 5'h10, 32'h1);
        check("irq_still_high", 64'(irq), 64'd1);
        idle();
        check("irq_dropped", 64'(irq), 64'd0);

        // 32-bit carry, and write-over-tick priority
        wr_chk("carry_hi", 5'h08, 32'h0);
        wr_chk("carry_lo", 5'h04, 32'hFFFF_FFFF);
        rd_chk("carry_lo_held", 5'h04, 32'hFFFF_FFFF);
        rd_chk("carry_hi1", 5'h08, 32'h1);
        rd_chk("carry_lo_after", 5'h04, 32'h1);

        // Reset asserted while a response is pending/visible
        wr_chk("rst_led", 5'h00, 32'hA);
        check("rst_led_pre", 64'(led), 64'hA);
        xfer(1'b0, 4'h0, 5'h00, 32'h0, gn, rv, rd, er);
        check("rst_rd_rvalid", 64'(rv), 64'd1);
        check("rst_rd_rdata", 64'(rd), 64'hA);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_rvalid", 64'(rvalid), 64'd0);
        check("rst_mid_rdata", 64'(rdata), 64'd0);
        check("rst_mid_led", 64'(led), 64'd0);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        rd_chk("post_rst_cmphi", 5'h10, 32'hFFFF_FFFF);
        rd_chk("post_rst_psc", 5'h14, 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
